monster_ctrl: RTL and testbench

- Downstream consumer of the scrolling 8-bit barrier window.
- Tracks the monster's jump height from a button, detects collisions with barriers at the monster's column, and runs the READY/RUN/OVER game state machine.
- Keeps a 4-digit BCD count of cleared barriers.
- Outputs feed the display and score-readout logic.

---
 rtl/monster_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_monster_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/monster_ctrl.sv
// Monster controller: button edge detect, jump height sequencer, barrier collision
// detection, READY/RUN/OVER game state and a saturating 4-digit BCD score.
module monster_ctrl #(
    parameter int MONSTER_COL = 6,
    parameter int AIR_TICKS   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [7:0]  barrier,
    input  logic        jump_btn,
    output logic [1:0]  monster_h,
    output logic        running,
    output logic        game_over,
    output logic        hit,
    output logic [15:0] score,
    output logic [3:0]  state_dbg
);

    typedef enum logic [1:0] {
        G_READY = 2'd0,
        G_RUN   = 2'd1,
        G_OVER  = 2'd2
    } game_t;

    typedef enum logic [1:0] {
        J_GROUND = 2'd0,
        J_RISE   = 2'd1,
        J_PEAK   = 2'd2,
        J_FALL   = 2'd3
    } jump_t;

    localparam logic [3:0] AIR_LAST = 4'(AIR_TICKS - 1);

    game_t       game_q, game_d;
    jump_t       jstate_q, jstate_d;
    logic [1:0]  h_q, h_d;
    logic [3:0]  air_cnt_q, air_cnt_d;
    logic        req_q, req_d;
    logic        hit_q, hit_d;
    logic [15:0] score_q, score_d;
    logic        jump_q;
    logic        running_q, game_over_q;

    logic press;
    logic bar_bit;
    logic collide;
    logic clear;
    logic unused_bar;

    assign press   = jump_btn & ~jump_q;
    assign bar_bit = barrier[MONSTER_COL];
    assign collide = tick & bar_bit & (h_q == 2'd0);
    assign clear   = tick & bar_bit & (h_q != 2'd0);

    // Only one column of the window matters to this block.
    assign unused_bar = ^barrier;

    function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (carry) begin
                    if (r[d*4 +: 4] == 4'd9) begin
                        r[d*4 +: 4] = 4'd0;
                    end else begin
                        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        game_d    = game_q;
        jstate_d  = jstate_q;
        h_d       = h_q;
        air_cnt_d = air_cnt_q;
        req_d     = req_q;
        hit_d     = 1'b0;
        score_d   = score_q;

        case (game_q)
            G_READY: begin
                if (press) begin
                    game_d  = G_RUN;
                    score_d = 16'h0000;
                end
            end

            G_RUN: begin
                if (collide) begin
                    // Jump sequencer freezes; height stays where it was.
                    hit_d  = 1'b1;
                    game_d = G_OVER;
                end else begin
                    if (clear) begin
                        score_d = bcd_inc_sat(score_q);
                    end

                    if (tick) begin
                        case (jstate_q)
                            J_GROUND: begin
                                if (req_q) begin
                                    jstate_d = J_RISE;
                                    h_d      = 2'd1;
                                end
                            end
                            J_RISE: begin
                                h_d = h_q + 2'd1;
                                if (h_q == 2'd2) begin
                                    jstate_d  = J_PEAK;
                                    air_cnt_d = 4'd0;
                                end
                            end
                            J_PEAK: begin
                                if (air_cnt_q == AIR_LAST) begin
                                    jstate_d  = J_FALL;
                                    air_cnt_d = 4'd0;
                                end else begin
                                    air_cnt_d = air_cnt_q + 4'd1;
                                end
                            end
                            J_FALL: begin
                                h_d = h_q - 2'd1;
                                if (h_q == 2'd1) begin
                                    jstate_d = J_GROUND;
                                end
                            end
                            default: jstate_d = J_GROUND;
                        endcase
                    end

                    // Requests are only accepted on the ground; airborne presses are dropped.
                    if (jstate_q == J_GROUND) begin
                        if (tick && req_q) begin
                            req_d = 1'b0;
                        end else if (press) begin
                            req_d = 1'b1;
                        end
                    end
                end
            end

            G_OVER: begin
                if (press) begin
                    game_d    = G_READY;
                    jstate_d  = J_GROUND;
                    h_d       = 2'd0;
                    air_cnt_d = 4'd0;
                    req_d     = 1'b0;
                end
            end

            default: game_d = G_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            game_q      <= G_READY;
            jstate_q    <= J_GROUND;
            h_q         <= 2'd0;
            air_cnt_q   <= 4'd0;
            req_q       <= 1'b0;
            hit_q       <= 1'b0;
            score_q     <= 16'h0000;
            jump_q      <= 1'b0;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            game_q      <= game_d;
            jstate_q    <= jstate_d;
            h_q         <= h_d;
            air_cnt_q   <= air_cnt_d;
            req_q       <= req_d;
            hit_q       <= hit_d;
            score_q     <= score_d;
            jump_q      <= jump_btn;
            running_q   <= (game_d == G_RUN);
            game_over_q <= (game_d == G_OVER);
        end
    end

    assign monster_h = h_q;
    assign running   = running_q;
    assign game_over = game_over_q;
    assign hit       = hit_q;
    assign score     = score_q;
    assign state_dbg = {game_q, jstate_q};

endmodule

// File: tb/tb_monster_ctrl.sv
// Bench for monster_ctrl: directed steps plus randomized play, compared every cycle
// against a jump-timeline / integer-score reference model.
module tb_monster_ctrl;

    localparam int COL = 6;
    localparam int AIR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [7:0]  barrier;
    logic        jump_btn;
    logic [1:0]  monster_h;
    logic        running;
    logic        game_over;
    logic        hit;
    logic [15:0] score;
    logic [3:0]  state_dbg;

    always #5 clk = ~clk;

    monster_ctrl #(.MONSTER_COL(COL), .AIR_TICKS(AIR)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .barrier   (barrier),
        .jump_btn  (jump_btn),
        .monster_h (monster_h),
        .running   (running),
        .game_over (game_over),
        .hit       (hit),
        .score     (score),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=ready 1=run 2=over; m_jt = ticks into current jump (0 = grounded).
    int m_mode  = 0;
    int m_jt    = 0;
    bit m_pend  = 1'b0;
    bit m_prev  = 1'b0;
    int m_score = 0;
    bit m_hit   = 1'b0;

    function automatic int height(input int t);
        if (t == 0) return 0;
        if (t <= 3) return t;
        if (t <= 3 + AIR) return 3;
        return 6 + AIR - t;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_step(input bit r, input bit b, input bit t, input logic [7:0] bar);
        bit press;
        if (r) begin
            m_mode = 0; m_jt = 0; m_pend = 1'b0; m_prev = 1'b0; m_score = 0; m_hit = 1'b0;
        end else begin
            press  = b && !m_prev;
            m_prev = b;
            m_hit  = 1'b0;
            case (m_mode)
                0: if (press) begin m_mode = 1; m_score = 0; end
                1: begin
                    if (t && bar[COL] && height(m_jt) == 0) begin
                        m_hit  = 1'b1;
                        m_mode = 2;
                    end else begin
                        if (t && bar[COL] && m_score < 9999) m_score = m_score + 1;
                        if (m_jt == 0 && t && m_pend) begin
                            m_jt   = 1;
                            m_pend = 1'b0;
                        end else if (m_jt == 0 && press) begin
                            m_pend = 1'b1;
                        end else if (m_jt > 0 && t) begin
                            m_jt = m_jt + 1;
                            if (m_jt == 6 + AIR) m_jt = 0;
                        end
                    end
                end
                default: if (press) begin m_mode = 0; m_jt = 0; m_pend = 1'b0; end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit b, input bit t, input logic [7:0] bar);
        @(negedge clk);
        rst = r; jump_btn = b; tick = t; barrier = bar;
        @(posedge clk);
        model_step(r, b, t, bar);
        #1;
        chk("monster_h", 16'(monster_h), 16'(height(m_jt)));
        chk("running", 16'(running), 16'(m_mode == 1));
        chk("game_over", 16'(game_over), 16'(m_mode == 2));
        chk("hit", 16'(hit), 16'(m_hit));
        chk("score", score, to_bcd(m_score));
    endtask

    task automatic to_run();
        for (int i = 0; i < 20 && m_mode != 1; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            cyc(1'b0, 1'b0, 1'b0, 8'h00);
        end
        chk("reach_run", 16'(running), 16'h0001);
    endtask

    // Continuous jumping with obstacles only under an airborne monster: every one is cleared.
    task automatic grind(input int target);
        bit b = 1'b0;
        for (int g = 0; g < 40000 && m_score < target; g++) begin
            b = ~b;
            cyc(1'b0, b, 1'b1, (8'($urandom) & 8'hBF) | ((height(m_jt) != 0) ? 8'h40 : 8'h00));
        end
    endtask

    logic [1:0] seq [8] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};

    initial begin
        rst = 1'b1; jump_btn = 1'b0; tick = 1'b0; barrier = 8'h00;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("dbg_known", 16'($isunknown(state_dbg)), 16'h0000);

        // READY ignores ticks and a full barrier window.
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, bit'(i % 2), 8'hFF);
        chk("ready_score", score, 16'h0000);
        chk("ready_run", 16'(running), 16'h0000);

        // Start, then 20 ticks with the monster column empty.
        cyc(1'b0, 1'b1, 1'b0, 8'($urandom) & 8'hBF);
        cyc(1'b0, 1'b0, 1'b0, 8'($urandom) & 8'hBF);
        chk("start_run", 16'(running), 16'h0001);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'($urandom) & 8'hBF);
            cyc(1'b0, 1'b0, 1'b0, 8'($urandom));
        end
        chk("empty_score", score, 16'h0000);
        chk("empty_over", 16'(game_over), 16'h0000);

        // Full jump profile, obstacles only while at peak height.
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 1'b1, (height(m_jt) == 3) ? 8'h40 : 8'h00);
            chk("jump_seq", 16'(monster_h), 16'(seq[k]));
            cyc(1'b0, 1'b0, 1'b0, 8'h00);
        end
        chk("peak_score", score, 16'h0003);
        chk("peak_nohit", 16'(game_over), 16'h0000);

        // Collision on the ground.
        cyc(1'b0, 1'b0, 1'b1, 8'h40);
        chk("coll_hit", 16'(hit), 16'h0001);
        chk("coll_over", 16'(game_over), 16'h0001);
        chk("coll_run", 16'(running), 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("hit_once", 16'(hit), 16'h0000);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 8'($urandom));
        chk("over_h", 16'(monster_h), 16'h0000);
        chk("over_score", score, 16'h0003);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("to_ready", 16'(game_over), 16'h0000);
        chk("ready_keep_score", score, 16'h0003);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("restart_run", 16'(running), 16'h0001);
        chk("restart_score", score, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Press on a tick cycle takes effect on the following tick.
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        chk("tick_press_h", 16'(monster_h), 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("tick_press_rise", 16'(monster_h), 16'h0001);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);

        // Randomized play.
        for (int i = 0; i < 400; i++)
            cyc(1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 8'($urandom));

        // Score carry and saturation.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        to_run();
        grind(999);
        chk("score_0999", score, 16'h0999);
        grind(1000);
        chk("score_1000", score, 16'h1000);
        grind(9999);
        chk("score_9999", score, 16'h9999);
        for (int i = 0; i < 24; i++)
            cyc(1'b0, bit'(i % 2), 1'b1, (height(m_jt) != 0) ? 8'h40 : 8'h00);
        chk("score_sat", score, 16'h9999);

        // Reset in the middle of the peak hold, with a press in the reset cycle.
        for (int i = 0; i < 60 && m_jt != 4; i++) cyc(1'b0, bit'(i % 2), 1'b1, 8'h00);
        chk("at_peak", 16'(monster_h), 16'h0003);
        cyc(1'b1, 1'b1, 1'b1, 8'hFF);
        chk("rst_h", 16'(monster_h), 16'h0000);
        chk("rst_score", score, 16'h0000);
        chk("rst_run", 16'(running), 16'h0000);
        chk("rst_hit", 16'(hit), 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_press_ignored", 16'(running), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
